// File: rtl/cfg_pkg.sv
// Build-wide configuration defaults shared across the "h" table blocks.
package cfg_pkg;

  localparam int RSP_DEPTH_DEFAULT = 8;

endpackage : cfg_pkg

// File: rtl/h_pkg.sv
// Shared types for the "h" table: command opcodes, key/value widths,
// completion status and the response record carried back to the client.
package h_pkg;

  localparam int K_W = 8;
  localparam int V_W = 16;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_GET = 2'd1,
    OP_PUT = 2'd2,
    OP_DEL = 2'd3
  } opcode_t;

  typedef logic [K_W-1:0] k_t;
  typedef logic [V_W-1:0] v_t;

  typedef enum logic [2:0] {
    ST_OK   = 3'd0,
    ST_HIT  = 3'd1,
    ST_MISS = 3'd2,
    ST_FULL = 3'd3,
    ST_ERR  = 3'd4
  } status_t;

  typedef struct packed {
    opcode_t opcode;
    k_t      k;
    v_t      v;
    status_t status;
  } rsp_t;

endpackage : h_pkg

// File: rtl/h_bdy_be_chk.sv
// Simulation-time checks on the response back end's slot accounting.
module h_bdy_be_chk #(
  parameter int RSP_DEPTH = 8,
  parameter int CW        = $clog2(RSP_DEPTH + 1)
) (
  input logic          clk,
  input logic          srst,
  input logic [CW-1:0] credit_cnt,
  input logic [CW-1:0] inflight_cnt,
  input logic [CW-1:0] occupancy
);

  // The queue can never hold more entries than it has slots.
  a_occ_bound : assert property (@(posedge clk) disable iff (srst)
    int'(occupancy) <= RSP_DEPTH);

  // Every slot is exactly one of: free credit, command in flight, queued result.
  a_credit_inv : assert property (@(posedge clk) disable iff (srst)
    (int'(credit_cnt) + int'(inflight_cnt) + int'(occupancy)) == RSP_DEPTH);

endmodule : h_bdy_be_chk

// File: rtl/h_bdy_be_q.sv
// In-order response queue with a registered head entry. The head register
// always mirrors the entry at the next read pointer, so the client sees a
// new entry the cycle after a push into an empty queue or after a pop.
module h_bdy_be_q
  import h_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          push,
  input  rsp_t          wdata,
  input  logic          pop,
  output rsp_t          head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic [AW:0] rd_ptr_nxt_s;
  logic        push_s;
  logic        pop_s;
  rsp_t        mem_r [DEPTH];
  rsp_t        head_r;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                 (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign count = CW'(wr_ptr_r - rd_ptr_r);
  assign head  = head_r;

  // Qualify push/pop against queue state and compute the post-pop read pointer.
  always_comb begin
    pop_s        = pop & ~empty;
    push_s       = push & (~full | pop_s);
    rd_ptr_nxt_s = rd_ptr_r + {{AW{1'b0}}, pop_s};
  end

  // Pointer update; pointers carry a wrap bit and roll over naturally.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r <= rd_ptr_nxt_s;
    end
  end

  // Storage write at the tail slot.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

  // Head register: take the incoming entry when it lands exactly at the next
  // read position (push into empty, or push while the last entry pops).
  always_ff @(posedge clk) begin
    if (srst) begin
      head_r <= '0;
    end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_r <= wdata;
    end else begin
      head_r <= mem_r[rd_ptr_nxt_s[AW-1:0]];
    end
  end

endmodule : h_bdy_be_q

// File: rtl/h_bdy_be.sv
// Response back end of the "h" table body. Buffers pipeline results in an
// in-order queue, hands them to the client on valid/ready, and issues
// credits so every command already has a reserved queue slot.
module h_bdy_be
  import h_pkg::*;
#(
  parameter int RSP_DEPTH = cfg_pkg::RSP_DEPTH_DEFAULT
) (
  input  logic    clk,
  input  logic    srst,
  input  logic    cmd_issue,
  output logic    cmd_credit,
  input  logic    res_vld,
  input  opcode_t res_opcode,
  input  k_t      res_k,
  input  v_t      res_v,
  input  status_t res_status,
  output logic    rsp_vld,
  input  logic    rsp_rdy,
  output opcode_t rsp_opcode,
  output k_t      rsp_k,
  output v_t      rsp_v,
  output status_t rsp_status,
  output logic    busy,
  output logic    err
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] DEPTH_CNT = CW'(RSP_DEPTH);

  logic [CW-1:0] credit_cnt_r;
  logic [CW-1:0] inflight_cnt_r;
  logic [CW-1:0] occ_s;
  logic          err_r;
  logic          issue_ok_s;
  logic          issue_bad_s;
  logic          push_ok_s;
  logic          push_bad_s;
  logic          pop_s;
  logic          q_full_s;
  logic          q_empty_s;
  rsp_t          res_s;
  rsp_t          head_s;

  // Classify this cycle's events; a result is only legal if a command is
  // in flight or is being issued in the same cycle.
  always_comb begin
    issue_ok_s    = cmd_issue & (credit_cnt_r != '0);
    issue_bad_s   = cmd_issue & (credit_cnt_r == '0);
    push_ok_s     = res_vld & ((inflight_cnt_r != '0) | issue_ok_s);
    push_bad_s    = res_vld & ~push_ok_s;
    pop_s         = ~q_empty_s & rsp_rdy;
    res_s.opcode  = res_opcode;
    res_s.k       = res_k;
    res_s.v       = res_v;
    res_s.status  = res_status;
  end

  h_bdy_be_q #(
    .DEPTH (RSP_DEPTH)
  ) u_q (
    .clk   (clk),
    .srst  (srst),
    .push  (push_ok_s),
    .wdata (res_s),
    .pop   (pop_s),
    .head  (head_s),
    .full  (q_full_s),
    .empty (q_empty_s),
    .count (occ_s)
  );

  // Free credits: an issue takes one, a pop returns one.
  always_ff @(posedge clk) begin
    if (srst) begin
      credit_cnt_r <= DEPTH_CNT;
    end else begin
      case ({issue_ok_s, pop_s})
        2'b10:   credit_cnt_r <= credit_cnt_r - CNT_ONE;
        2'b01:   credit_cnt_r <= credit_cnt_r + CNT_ONE;
        default: credit_cnt_r <= credit_cnt_r;
      endcase
    end
  end

  // Commands in the pipeline: an issue adds one, an accepted result retires one.
  always_ff @(posedge clk) begin
    if (srst) begin
      inflight_cnt_r <= '0;
    end else begin
      case ({issue_ok_s, push_ok_s})
        2'b10:   inflight_cnt_r <= inflight_cnt_r + CNT_ONE;
        2'b01:   inflight_cnt_r <= inflight_cnt_r - CNT_ONE;
        default: inflight_cnt_r <= inflight_cnt_r;
      endcase
    end
  end

  // Sticky protocol-violation flag: issue without credit or unexpected result.
  always_ff @(posedge clk) begin
    if (srst) begin
      err_r <= 1'b0;
    end else if (issue_bad_s | push_bad_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign cmd_credit = (credit_cnt_r != '0);
  assign rsp_vld    = ~q_empty_s;
  assign rsp_opcode = head_s.opcode;
  assign rsp_k      = head_s.k;
  assign rsp_v      = head_s.v;
  assign rsp_status = head_s.status;
  assign busy       = (inflight_cnt_r != '0) | ~q_empty_s;
  assign err        = err_r;

  h_bdy_be_chk #(
    .RSP_DEPTH (RSP_DEPTH)
  ) u_chk (
    .clk          (clk),
    .srst         (srst),
    .credit_cnt   (credit_cnt_r),
    .inflight_cnt (inflight_cnt_r),
    .occupancy    (occ_s)
  );

endmodule : h_bdy_be

// File: tb/tb_h_bdy_be.sv
// Bench for the response back end: directed scenarios plus a randomized run,
// all checked against a slot-accounting model built from queues and integers.
module tb_h_bdy_be;
  import h_pkg::*;

  localparam int D = 8;

  logic    clk = 1'b0;
  logic    srst = 1'b0;
  logic    cmd_issue = 1'b0;
  logic    cmd_credit;
  logic    res_vld = 1'b0;
  opcode_t res_opcode = OP_NOP;
  k_t      res_k = '0;
  v_t      res_v = '0;
  status_t res_status = ST_OK;
  logic    rsp_vld;
  logic    rsp_rdy = 1'b0;
  opcode_t rsp_opcode;
  k_t      rsp_k;
  v_t      rsp_v;
  status_t rsp_status;
  logic    busy;
  logic    err;

  always #5 clk = ~clk;

  h_bdy_be #(.RSP_DEPTH(D)) dut (
    .clk        (clk),
    .srst       (srst),
    .cmd_issue  (cmd_issue),
    .cmd_credit (cmd_credit),
    .res_vld    (res_vld),
    .res_opcode (res_opcode),
    .res_k      (res_k),
    .res_v      (res_v),
    .res_status (res_status),
    .rsp_vld    (rsp_vld),
    .rsp_rdy    (rsp_rdy),
    .rsp_opcode (rsp_opcode),
    .rsp_k      (rsp_k),
    .rsp_v      (rsp_v),
    .rsp_status (rsp_status),
    .busy       (busy),
    .err        (err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int   m_credit   = D;
  int   m_inflight = 0;
  bit   m_err      = 1'b0;
  rsp_t m_q[$];
  rsp_t exp_pop_q[$];
  rsp_t obs_pop_q[$];

  function automatic rsp_t rnd_rsp(input logic [7:0] k);
    rsp_t r;
    r.opcode = opcode_t'(2'($urandom_range(3)));
    r.k      = k;
    r.v      = 16'($urandom);
    r.status = status_t'(3'($urandom_range(4)));
    return r;
  endfunction

  task automatic drive_res(input rsp_t r);
    res_vld    = 1'b1;
    res_opcode = r.opcode;
    res_k      = r.k;
    res_v      = r.v;
    res_status = r.status;
  endtask

  // One clock: record any handshake, advance the model, return 1 after the edge.
  task automatic tick();
    rsp_t obs;
    rsp_t nw;
    bit   iss;
    bit   psh;
    bit   pp;
    @(negedge clk);
    if (srst) begin
      m_credit   = D;
      m_inflight = 0;
      m_err      = 1'b0;
      m_q.delete();
    end else begin
      if (rsp_vld && rsp_rdy) begin
        obs.opcode = rsp_opcode;
        obs.k      = rsp_k;
        obs.v      = rsp_v;
        obs.status = rsp_status;
        obs_pop_q.push_back(obs);
      end
      iss = cmd_issue && (m_credit > 0);
      if (cmd_issue && !iss) m_err = 1'b1;
      psh = res_vld && ((m_inflight > 0) || iss);
      if (res_vld && !psh) m_err = 1'b1;
      pp = (m_q.size() > 0) && rsp_rdy;
      if (pp) exp_pop_q.push_back(m_q.pop_front());
      if (psh) begin
        nw.opcode = res_opcode;
        nw.k      = res_k;
        nw.v      = res_v;
        nw.status = res_status;
        m_q.push_back(nw);
      end
      m_credit   = m_credit + (pp ? 1 : 0) - (iss ? 1 : 0);
      m_inflight = m_inflight + (iss ? 1 : 0) - (psh ? 1 : 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cmd_issue = 1'b0;
    res_vld   = 1'b0;
    rsp_rdy   = 1'b0;
    srst      = 1'b1;
    tick();
    srst = 1'b0;
    tick();
    obs_pop_q.delete();
    exp_pop_q.delete();
  endtask

  task automatic test_reset();
    srst = 1'b1;
    tick();
    n_checks++;
    if (cmd_credit !== 1'b1) $display("FAIL reset_credit_early: got %0b want 1", cmd_credit);
    else n_pass++;
    tick();
    srst = 1'b0;
    tick();
    n_checks++;
    if (cmd_credit !== 1'b1) $display("FAIL reset_credit: got %0b want 1", cmd_credit);
    else n_pass++;
    n_checks++;
    if (rsp_vld !== 1'b0) $display("FAIL reset_rsp_vld: got %0b want 0", rsp_vld);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL reset_err: got %0b want 0", err);
    else n_pass++;
    n_checks++;
    if (int'(dut.credit_cnt_r) !== D) $display("FAIL reset_credit_cnt: got %0d want %0d", dut.credit_cnt_r, D);
    else n_pass++;
  endtask

  task automatic test_single();
    rsp_t r;
    do_reset();
    rsp_rdy   = 1'b1;
    cmd_issue = 1'b1;
    tick();
    cmd_issue = 1'b0;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b1 || rsp_vld !== 1'b0) $display("FAIL single_inflight: got busy=%0b vld=%0b want busy=1 vld=0", busy, rsp_vld);
    else n_pass++;
    r.opcode = OP_GET; r.k = 8'h12; r.v = 16'h3456; r.status = ST_HIT;
    drive_res(r);
    tick();
    res_vld = 1'b0;
    n_checks++;
    if (rsp_vld !== 1'b1) $display("FAIL single_vld: got %0b want 1", rsp_vld);
    else n_pass++;
    n_checks++;
    if (rsp_opcode !== OP_GET || rsp_k !== 8'h12 || rsp_v !== 16'h3456 || rsp_status !== ST_HIT)
      $display("FAIL single_payload: got op=%0d k=%0h v=%0h st=%0d want op=1 k=12 v=3456 st=1",
               rsp_opcode, rsp_k, rsp_v, rsp_status);
    else n_pass++;
    tick();
    n_checks++;
    if (busy !== 1'b0 || rsp_vld !== 1'b0) $display("FAIL single_idle: got busy=%0b vld=%0b want 0 0", busy, rsp_vld);
    else n_pass++;
    n_checks++;
    if (int'(dut.credit_cnt_r) !== D) $display("FAIL single_credit: got %0d want %0d", dut.credit_cnt_r, D);
    else n_pass++;
    n_checks++;
    if (obs_pop_q.size() !== 1) $display("FAIL single_count: got %0d want 1", obs_pop_q.size());
    else n_pass++;
  endtask

  task automatic test_credit_exhaust();
    do_reset();
    rsp_rdy = 1'b0;
    for (int i = 0; i < D; i++) begin
      cmd_issue = 1'b1;
      tick();
    end
    n_checks++;
    if (cmd_credit !== 1'b0) $display("FAIL exh_credit_zero: got %0b want 0", cmd_credit);
    else n_pass++;
    tick();
    cmd_issue = 1'b0;
    n_checks++;
    if (err !== 1'b1 || dut.credit_cnt_r !== '0) $display("FAIL exh_illegal_issue: got err=%0b cnt=%0d want 1 0", err, dut.credit_cnt_r);
    else n_pass++;
    for (int i = 0; i < D; i++) begin
      drive_res(rnd_rsp(8'(i)));
      tick();
    end
    res_vld = 1'b0;
    n_checks++;
    if (dut.q_full_s !== 1'b1 || rsp_vld !== 1'b1 || cmd_credit !== 1'b0)
      $display("FAIL exh_full: got full=%0b vld=%0b credit=%0b want 1 1 0", dut.q_full_s, rsp_vld, cmd_credit);
    else n_pass++;
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    n_checks++;
    if (cmd_credit !== 1'b1) $display("FAIL exh_credit_back: got %0b want 1", cmd_credit);
    else n_pass++;
    n_checks++;
    if (int'(dut.u_q.count) !== D - 1) $display("FAIL exh_remaining: got %0d want %0d", dut.u_q.count, D - 1);
    else n_pass++;
    rsp_rdy = 1'b1;
    for (int i = 0; i < D + 2; i++) tick();
    rsp_rdy = 1'b0;
    n_checks++;
    if (obs_pop_q.size() !== D || exp_pop_q.size() !== D)
      $display("FAIL exh_drain_count: got %0d want %0d", obs_pop_q.size(), D);
    else n_pass++;
    for (int i = 0; i < obs_pop_q.size() && i < exp_pop_q.size(); i++) begin
      n_checks++;
      if (obs_pop_q[i] !== exp_pop_q[i] || obs_pop_q[i].k !== 8'(i))
        $display("FAIL exh_order[%0d]: got %0h want %0h", i, obs_pop_q[i], exp_pop_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    rsp_t held;
    bit   stalled;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cmd_issue = 1'b1;
      tick();
    end
    cmd_issue = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive_res(rnd_rsp(8'(i)));
      tick();
    end
    res_vld = 1'b0;
    for (int c = 0; c < 40; c++) begin
      rsp_rdy     = 1'($urandom_range(1));
      stalled     = rsp_vld && !rsp_rdy;
      held.opcode = rsp_opcode;
      held.k      = rsp_k;
      held.v      = rsp_v;
      held.status = rsp_status;
      tick();
      if (stalled) begin
        n_checks++;
        if (rsp_vld !== 1'b1 || rsp_opcode !== held.opcode || rsp_k !== held.k ||
            rsp_v !== held.v || rsp_status !== held.status)
          $display("FAIL bp_stable[%0d]: got vld=%0b k=%0h v=%0h want vld=1 k=%0h v=%0h",
                   c, rsp_vld, rsp_k, rsp_v, held.k, held.v);
        else n_pass++;
      end
    end
    rsp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (obs_pop_q.size() !== 3) $display("FAIL bp_count: got %0d want 3", obs_pop_q.size());
    else n_pass++;
    for (int i = 0; i < obs_pop_q.size() && i < exp_pop_q.size(); i++) begin
      n_checks++;
      if (obs_pop_q[i] !== exp_pop_q[i] || obs_pop_q[i].k !== 8'(i + 1))
        $display("FAIL bp_order[%0d]: got %0h want %0h", i, obs_pop_q[i], exp_pop_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_streaming();
    int gaps;
    do_reset();
    rsp_rdy = 1'b1;
    gaps    = 0;
    for (int i = 0; i < 100; i++) begin
      cmd_issue = 1'b1;
      drive_res(rnd_rsp(8'(i)));
      tick();
      if (rsp_vld !== 1'b1) gaps++;
    end
    cmd_issue = 1'b0;
    res_vld   = 1'b0;
    n_checks++;
    if (gaps !== 0) $display("FAIL stream_continuous: got %0d bubbles want 0", gaps);
    else n_pass++;
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (obs_pop_q.size() !== 100) $display("FAIL stream_count: got %0d want 100", obs_pop_q.size());
    else n_pass++;
    for (int i = 0; i < obs_pop_q.size() && i < exp_pop_q.size(); i++) begin
      n_checks++;
      if (obs_pop_q[i] !== exp_pop_q[i] || obs_pop_q[i].k !== 8'(i))
        $display("FAIL stream_order[%0d]: got %0h want %0h", i, obs_pop_q[i], exp_pop_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b0) $display("FAIL stream_end: got err=%0b busy=%0b want 0 0", err, busy);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      cmd_issue = (m_credit > 0) && ($urandom_range(99) < 60);
      if ((m_inflight > 0 || cmd_issue) && ($urandom_range(99) < 55)) drive_res(rnd_rsp(8'(c)));
      else res_vld = 1'b0;
      rsp_rdy = ($urandom_range(99) < 50);
      tick();
      n_checks++;
      if (cmd_credit !== (m_credit != 0) || rsp_vld !== (m_q.size() != 0) ||
          busy !== ((m_inflight != 0) || (m_q.size() != 0)) || err !== m_err)
        $display("FAIL rand_state[%0d]: got credit=%0b vld=%0b busy=%0b err=%0b want %0b %0b %0b %0b",
                 c, cmd_credit, rsp_vld, busy, err, m_credit != 0, m_q.size() != 0,
                 (m_inflight != 0) || (m_q.size() != 0), m_err);
      else n_pass++;
    end
    cmd_issue = 1'b0;
    res_vld   = 1'b0;
    rsp_rdy   = 1'b1;
    for (int i = 0; i < D + 2; i++) tick();
    n_checks++;
    if (obs_pop_q.size() !== exp_pop_q.size() || exp_pop_q.size() == 0)
      $display("FAIL rand_count: got %0d want %0d", obs_pop_q.size(), exp_pop_q.size());
    else n_pass++;
    for (int i = 0; i < obs_pop_q.size() && i < exp_pop_q.size(); i++) begin
      n_checks++;
      if (obs_pop_q[i] !== exp_pop_q[i])
        $display("FAIL rand_data[%0d]: got %0h want %0h", i, obs_pop_q[i], exp_pop_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_violation_reset();
    do_reset();
    rsp_rdy = 1'b1;
    drive_res(rnd_rsp(8'h55));
    tick();
    res_vld = 1'b0;
    n_checks++;
    if (err !== 1'b1 || rsp_vld !== 1'b0 || busy !== 1'b0)
      $display("FAIL viol_result: got err=%0b vld=%0b busy=%0b want 1 0 0", err, rsp_vld, busy);
    else n_pass++;
    tick();
    n_checks++;
    if (obs_pop_q.size() !== 0 || rsp_vld !== 1'b0) $display("FAIL viol_no_rsp: got %0d responses want 0", obs_pop_q.size());
    else n_pass++;
    rsp_rdy   = 1'b0;
    cmd_issue = 1'b1;
    tick();
    tick();
    cmd_issue = 1'b0;
    drive_res(rnd_rsp(8'h66));
    tick();
    res_vld = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || rsp_vld !== 1'b1) $display("FAIL viol_midflight: got busy=%0b vld=%0b want 1 1", busy, rsp_vld);
    else n_pass++;
    srst = 1'b1;
    tick();
    srst = 1'b0;
    n_checks++;
    if (int'(dut.credit_cnt_r) !== D || dut.inflight_cnt_r !== '0)
      $display("FAIL viol_rst_cnts: got credit=%0d inflight=%0d want %0d 0", dut.credit_cnt_r, dut.inflight_cnt_r, D);
    else n_pass++;
    n_checks++;
    if (rsp_vld !== 1'b0 || err !== 1'b0 || cmd_credit !== 1'b1 || busy !== 1'b0)
      $display("FAIL viol_rst_out: got vld=%0b err=%0b credit=%0b busy=%0b want 0 0 1 0", rsp_vld, err, cmd_credit, busy);
    else n_pass++;
    drive_res(rnd_rsp(8'h77));
    tick();
    res_vld = 1'b0;
    n_checks++;
    if (err !== 1'b1 || rsp_vld !== 1'b0) $display("FAIL viol_post_rst: got err=%0b vld=%0b want 1 0", err, rsp_vld);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_credit_exhaust();
    test_backpressure();
    test_streaming();
    test_random();
    test_violation_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_h_bdy_be

// File: doc/h_bdy_be.md
Name: h_bdy_be

Overview:
- Response back end of the "h" table body; the return-direction counterpart of the command front end.
- Accepts one result per cycle from the table pipeline and buffers it in an in-order response queue.
- Presents results to the client on a valid/ready response interface.
- Issues credits to the command front end so every issued command has a guaranteed queue slot; a result is never dropped for lack of space.

Parameters:
RSP_DEPTH, 8, response queue entries and initial credit count; power of two, >= 2.

Ports:
clk  in  1  clock
srst  in  1  synchronous reset, active-high
cmd_issue  in  1  pulse: front end committed one command to the pipeline; consumes one credit
cmd_credit  out  1  high when at least one credit is available
res_vld  in  1  pipeline result valid
res_opcode  in  h_pkg::opcode_t  opcode of completed command
res_k  in  h_pkg::k_t  key
res_v  in  h_pkg::v_t  value (read data or written value)
res_status  in  h_pkg::status_t  completion status
rsp_vld  out  1  response valid
rsp_rdy  in  1  client ready
rsp_opcode  out  h_pkg::opcode_t  response opcode
rsp_k  out  h_pkg::k_t  response key
rsp_v  out  h_pkg::v_t  response value
rsp_status  out  h_pkg::status_t  response status
busy  out  1  commands in flight or responses queued
err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (srst high at a clk edge):
  - rsp_vld=0; queue empty; credit_cnt=RSP_DEPTH; inflight_cnt=0; busy=0; err=0.
  - cmd_credit=1 the cycle after reset.
  - rsp_* payload is don't-care while rsp_vld=0.
  - Reset mid-operation discards all queued and in-flight state; results arriving after reset with inflight_cnt=0 set err.
- Counter widths: $clog2(RSP_DEPTH+1).
- Credits:
  - cmd_credit = (credit_cnt != 0), combinational from the register.
  - cmd_issue decrements credit_cnt; a pop (rsp_vld & rsp_rdy) increments it.
  - Both in the same cycle: credit_cnt unchanged.
  - Invariant: credit_cnt + inflight_cnt + occupancy == RSP_DEPTH.
- In-flight:
  - cmd_issue increments inflight_cnt; res_vld decrements it.
  - Both in the same cycle: inflight_cnt unchanged.
- Push:
  - res_vld writes the result into the queue tail; results are written in arrival order.
  - res_vld=1 with inflight_cnt=0 (and no simultaneous cmd_issue) is illegal: the result is dropped, counters are unchanged, and err is set.
- Illegal issue:
  - cmd_issue=1 with credit_cnt=0 is ignored, with no counter change, and sets err.
- Pop / output:
  - rsp_vld = !empty; rsp_* is driven from the registered queue head.
  - A result pushed at cycle t into an empty queue gives rsp_vld=1 at t+1. There is no combinational res->rsp bypass.
  - The head pops when rsp_vld & rsp_rdy. The next entry is visible the following cycle, giving 1 response/cycle at full throughput.
  - While rsp_vld & !rsp_rdy, all rsp_* hold stable.
  - Once asserted, rsp_vld does not drop without a pop.
- Simultaneous events:
  - Push and pop with a full queue is legal; occupancy stays at RSP_DEPTH.
  - Push to an empty queue with rsp_rdy=1 does not pop in that cycle.
- Pointers: log2(RSP_DEPTH) bits plus a wrap bit. full/empty come from pointer compare; pointers wrap naturally.
- busy = (inflight_cnt != 0) | !empty.
- err is sticky until srst.
- Assertions (sim only):
  - occupancy never exceeds RSP_DEPTH.
  - The credit invariant holds every cycle.

Decomposition:
- h_pkg gains:
  - status_t enum: ST_OK, ST_HIT, ST_MISS, ST_FULL, ST_ERR.
  - rsp_t struct: {opcode_t, k_t, v_t, status_t}.
- cfg_pkg gains RSP_DEPTH_DEFAULT=8.
- One sub-module, h_bdy_be_q: a synchronous-reset FIFO of rsp_t with registered head output, push/pop/full/empty, parameterized by depth.
- Credit and in-flight counters plus the err flag stay in h_bdy_be.

Test Plan:
- Reset then idle: cmd_credit=1, rsp_vld=0, busy=0, err=0; credit_cnt=8.
- Single transaction:
  - Stimulus: cmd_issue@t0; res_vld@t3 with {GET,k=0x12,v=0x3456,ST_HIT}; rsp_rdy=1.
  - Response: rsp_vld@t4 with identical payload, popped @t4; busy=0 @t5; credit back to 8.
- Credit exhaustion and recovery:
  - Stimulus: 8 cmd_issue, 8 results, rsp_rdy=0.
  - Response: cmd_credit=0 and queue full.
  - Then rsp_rdy=1 for 1 cycle: cmd_credit=1 next cycle; 7 entries remain in order.
- Backpressure stability:
  - Stimulus: 3 results queued; toggle rsp_rdy 0/1 randomly.
  - Response: payload constant while stalled; order k=1,2,3 preserved; no duplicates.
- Full-throughput streaming:
  - Stimulus: cmd_issue and res_vld every cycle for 100 cycles; rsp_rdy=1.
  - Response: rsp_vld continuous after first fill; all 100 responses in order; err=0.
- Violations and reset:
  - Stimulus: res_vld with no issue.
  - Response: err=1, no response emitted.
  - Then 2 issues + 1 result, assert srst mid-flight: next cycle all counters reset, rsp_vld=0, err=0, cmd_credit=1.
